mcu_timer_bank: RTL and testbench

Parametrised multi-channel timer for the MCU peripheral region of the creator core, next generation of the single 16-bit enable-gated timer. Provides NCH independent channels, each with its own prescaler, a compare register and a selectable free-run, periodic or one-shot mode. Per-channel match pulses, one-shot done status and sticky overflow flags are provided for the MCU. With the default CLK_DIV = 200 at the 200 MHz core clock, one count LSB is 1 µs (200 × 5 ns).

---
 rtl/mcu_timer_bank_pkg.sv | 20 ++
 rtl/mcu_timer_bank_ch.sv | 96 +++++++++
 rtl/mcu_timer_bank.sv | 40 ++++
 tb/tb_mcu_timer_bank.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mcu_timer_bank_pkg.sv
// Shared definitions for the MCU timer bank: mode and channel-state encodings
// plus the prescaler width helper.
package mcu_timer_bank_pkg;

  localparam logic [1:0] MODE_FREE     = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;
  localparam logic [1:0] MODE_ONESHOT  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Prescaler needs clog2(CLK_DIV) bits, but never fewer than one.
  function automatic int psc_width(input int clk_div);
    return (clk_div > 1) ? $clog2(clk_div) : 1;
  endfunction

endpackage

// File: rtl/mcu_timer_bank_ch.sv
// One timer channel: prescaler, counter, run/idle/done state machine,
// registered match pulse and sticky overflow flag.
module mcu_timer_ch
  import mcu_timer_bank_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] cmp,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] timer_out,
  output logic             match,
  output logic             done,
  output logic             ovf
);

  localparam int             PW      = psc_width(CLK_DIV);
  localparam logic [PW-1:0]  PSC_MAX = PW'(CLK_DIV - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  state_e           state_r, state_s;
  logic [PW-1:0]    psc_r, psc_s;
  logic [WIDTH-1:0] count_r, count_s;
  logic             match_r, match_s;
  logic             ovf_r, ovf_s;
  logic             done_r, done_s;
  logic             ovf_set_s;

  // Next-state logic. The edge that first samples enable high already counts
  // as prescaler cycle 0, so the first tick lands CLK_DIV-1 edges later.
  always_comb begin
    state_s   = state_r;
    psc_s     = psc_r;
    count_s   = count_r;
    match_s   = 1'b0;
    ovf_set_s = 1'b0;
    if (!enable) begin
      state_s = ST_IDLE;
      psc_s   = {PW{1'b0}};
      count_s = {WIDTH{1'b0}};
    end else if (state_r == ST_DONE) begin
      psc_s = {PW{1'b0}};
    end else begin
      state_s = ST_RUN;
      psc_s   = (psc_r == PSC_MAX) ? {PW{1'b0}} : psc_r + PW'(1);
      if (psc_r == PSC_MAX) begin
        if (count_r == cmp) begin
          match_s = 1'b1;
          case (mode)
            MODE_PERIODIC: count_s = {WIDTH{1'b0}};
            MODE_ONESHOT:  state_s = ST_DONE;
            default:       count_s = count_r + WIDTH'(1);
          endcase
        end else if (count_r == CNT_MAX) begin
          count_s   = {WIDTH{1'b0}};
          ovf_set_s = 1'b1;
        end else begin
          count_s = count_r + WIDTH'(1);
        end
      end else begin
        count_s = count_r;
      end
    end
    ovf_s  = ovf_set_s ? 1'b1 : (clr_flags ? 1'b0 : ovf_r);
    done_s = (state_s == ST_DONE);
  end

  // Channel state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      psc_r   <= {PW{1'b0}};
      count_r <= {WIDTH{1'b0}};
      match_r <= 1'b0;
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      psc_r   <= psc_s;
      count_r <= count_s;
      match_r <= match_s;
      ovf_r   <= ovf_s;
      done_r  <= done_s;
    end
  end

  assign timer_out = count_r;
  assign match     = match_r;
  assign done      = done_r;
  assign ovf       = ovf_r;

endmodule

// File: rtl/mcu_timer_bank.sv
// Multi-channel MCU timer: NCH independent mcu_timer_ch instances with
// per-channel slices of the packed mode/cmp/timer_out vectors.
module mcu_timer_bank
  import mcu_timer_bank_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NCH     = 4,
  parameter int CLK_DIV = 200
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       enable,
  input  logic [2*NCH-1:0]     mode,
  input  logic [NCH*WIDTH-1:0] cmp,
  input  logic [NCH-1:0]       clr_flags,
  output logic [NCH*WIDTH-1:0] timer_out,
  output logic [NCH-1:0]       match,
  output logic [NCH-1:0]       done,
  output logic [NCH-1:0]       ovf
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    mcu_timer_ch #(
      .WIDTH   (WIDTH),
      .CLK_DIV (CLK_DIV)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable[i]),
      .mode      (mode[2*i +: 2]),
      .cmp       (cmp[WIDTH*i +: WIDTH]),
      .clr_flags (clr_flags[i]),
      .timer_out (timer_out[WIDTH*i +: WIDTH]),
      .match     (match[i]),
      .done      (done[i]),
      .ovf       (ovf[i])
    );
  end

endmodule

// File: tb/tb_mcu_timer_bank.sv
// Self-checking bench for mcu_timer_bank (WIDTH=8, NCH=2, CLK_DIV=4): directed
// scenarios plus random stimulus, all compared against a behavioural model.
module tb_mcu_timer_bank;

  localparam int WIDTH   = 8;
  localparam int NCH     = 2;
  localparam int CLK_DIV = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NCH-1:0]       enable;
  logic [2*NCH-1:0]     mode;
  logic [NCH*WIDTH-1:0] cmp;
  logic [NCH-1:0]       clr_flags;
  logic [NCH*WIDTH-1:0] timer_out;
  logic [NCH-1:0]       match;
  logic [NCH-1:0]       done;
  logic [NCH-1:0]       ovf;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: age counts enabled cycles in the current run; a tick
  // happens whenever age reaches a multiple of CLK_DIV.
  int m_cnt   [NCH];
  int m_age   [NCH];
  bit m_fin   [NCH];
  bit m_match [NCH];
  bit m_ovf   [NCH];

  mcu_timer_bank #(
    .WIDTH   (WIDTH),
    .NCH     (NCH),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .cmp       (cmp),
    .clr_flags (clr_flags),
    .timer_out (timer_out),
    .match     (match),
    .done      (done),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    for (int c = 0; c < NCH; c++) begin
      int md;
      int cv;
      bit set_ovf;
      md = int'(mode[2*c +: 2]);
      cv = int'(cmp[WIDTH*c +: WIDTH]);
      set_ovf = 1'b0;
      m_match[c] = 1'b0;
      if (reset) begin
        m_cnt[c] = 0; m_age[c] = 0; m_fin[c] = 1'b0; m_ovf[c] = 1'b0;
      end else begin
        if (!enable[c]) begin
          m_cnt[c] = 0; m_age[c] = 0; m_fin[c] = 1'b0;
        end else if (!m_fin[c]) begin
          m_age[c]++;
          if (m_age[c] % CLK_DIV == 0) begin
            if (m_cnt[c] == cv) begin
              m_match[c] = 1'b1;
              if (md == 1) m_cnt[c] = 0;
              else if (md == 2) m_fin[c] = 1'b1;
              else m_cnt[c] = (m_cnt[c] + 1) % (1 << WIDTH);
            end else if (m_cnt[c] == (1 << WIDTH) - 1) begin
              m_cnt[c] = 0;
              set_ovf = 1'b1;
            end else begin
              m_cnt[c] = m_cnt[c] + 1;
            end
          end
        end
        if (set_ovf) m_ovf[c] = 1'b1;
        else if (clr_flags[c]) m_ovf[c] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NCH; c++) begin
      check_eq($sformatf("count ch%0d", c), 32'(timer_out[WIDTH*c +: WIDTH]), 32'(m_cnt[c]));
      check_eq($sformatf("match ch%0d", c), 32'(match[c]), 32'(m_match[c]));
      check_eq($sformatf("done ch%0d", c),  32'(done[c]),  32'(m_fin[c]));
      check_eq($sformatf("ovf ch%0d", c),   32'(ovf[c]),   32'(m_ovf[c]));
    end
  endtask

  // Inputs are set at the falling edge; the model predicts the next rising edge.
  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int hits;
    int guard;

    reset = 1'b1; enable = 2'b11; clr_flags = 2'b00;
    mode = {2'b00, 2'b01}; cmp = {8'd0, 8'd3};
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0; m_age[c] = 0; m_fin[c] = 1'b0; m_match[c] = 1'b0; m_ovf[c] = 1'b0;
    end
    @(negedge clk);

    // Reset held with both channels enabled.
    steps(3);
    check_eq("reset timer_out", 32'(timer_out), 32'd0);
    check_eq("reset match", 32'(match), 32'd0);
    check_eq("reset done", 32'(done), 32'd0);
    check_eq("reset ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    steps(3);
    check_eq("first tick early", 32'(timer_out[7:0]), 32'd0);
    step();
    check_eq("first tick", 32'(timer_out[7:0]), 32'd1);

    // PERIODIC ch0 cmp=3: exactly two match pulses in any 32-cycle window.
    hits = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (match[0]) begin
        hits++;
        check_eq("periodic wrap on match", 32'(timer_out[7:0]), 32'd0);
      end
    end
    check_eq("periodic match count", 32'(hits), 32'd2);

    // ONESHOT ch1 cmp=5.
    enable = 2'b00; step();
    mode = {2'b10, 2'b01}; cmp = {8'd5, 8'd3}; enable = 2'b10;
    hits = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (match[1]) hits++;
    end
    check_eq("oneshot match count", 32'(hits), 32'd1);
    check_eq("oneshot done", 32'(done[1]), 32'd1);
    check_eq("oneshot frozen", 32'(timer_out[15:8]), 32'd5);
    enable = 2'b00; step();
    check_eq("oneshot done cleared", 32'(done[1]), 32'd0);
    check_eq("oneshot count cleared", 32'(timer_out[15:8]), 32'd0);

    // FREE ch0 cmp=200 up to overflow, with clr_flags colliding with the set.
    mode = {2'b00, 2'b00}; cmp = {8'd0, 8'd200}; enable = 2'b01;
    guard = 0;
    while (!(m_cnt[0] == 255 && (m_age[0] + 1) % CLK_DIV == 0) && guard < 2000) begin
      step(); guard++;
    end
    check_eq("free reach 255 bound", 32'(guard < 2000), 32'd1);
    clr_flags = 2'b01; step(); clr_flags = 2'b00;
    check_eq("ovf set beats clear", 32'(ovf[0]), 32'd1);
    steps(2);
    clr_flags = 2'b01; step(); clr_flags = 2'b00;
    check_eq("ovf cleared", 32'(ovf[0]), 32'd0);

    // Mid-run cmp change below the current count, then reset mid-run.
    enable = 2'b00; step();
    mode = {2'b00, 2'b01}; cmp = {8'd0, 8'd10}; enable = 2'b01;
    guard = 0;
    while (m_cnt[0] != 6 && guard < 200) begin
      step(); guard++;
    end
    check_eq("reach count 6 bound", 32'(guard < 200), 32'd1);
    cmp = {8'd0, 8'd2};
    steps(1100);
    check_eq("midrun ovf", 32'(ovf[0]), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    check_eq("midrun reset timer_out", 32'(timer_out), 32'd0);
    check_eq("midrun reset ovf", 32'(ovf), 32'd0);

    // Channel independence: enables staggered by 3 cycles.
    mode = {2'b10, 2'b01}; cmp = {8'd9, 8'd3}; enable = 2'b01;
    steps(3);
    enable = 2'b11;
    steps(60);
    enable = 2'b01;
    steps(12);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) enable[$urandom_range(0, NCH-1)] ^= 1'b1;
      if ($urandom_range(0, 63) == 0) mode = 4'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        if ($urandom_range(0, 1) == 1) cmp = 16'($urandom);
        else cmp = {8'($urandom_range(0, 12)), 8'($urandom_range(0, 12))};
      end
      clr_flags = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
      reset = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
